// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: 8 lines of 4 bytes, 8-bit CPU port, 32-bit memory blocks.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    output logic        busywait,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    input  logic [7:0]  address,
    input  logic        mem_busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    output logic [5:0]  mem_address
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t           state;
    state_t           next_state;
    logic [7:0][31:0] data_array;
    logic [7:0][2:0]  tag_array;
    logic [7:0]       valid;
    logic [7:0]       dirty;
    logic [7:0]       readdata_q;

    logic [2:0]  addr_tag;
    logic [2:0]  index;
    logic [4:0]  bit_base;
    logic [31:0] line_data;
    logic [7:0]  sel_byte;
    logic        req;
    logic        hit;
    logic        hit_done;
    logic        fill_done;

    assign addr_tag  = address[7:5];
    assign index     = address[4:2];
    assign bit_base  = {address[1:0], 3'b000};
    assign line_data = data_array[index];
    assign sel_byte  = line_data[bit_base +: 8];
    assign req       = read | write;
    assign hit       = valid[index] && (tag_array[index] == addr_tag);
    assign hit_done  = (state == IDLE) && req && hit;
    assign fill_done = (state == ALLOCATE) && !mem_busywait;

    // Gated by RESET so the stall drops the moment reset is asserted, even with a request held.
    assign busywait = RESET && ((req && !hit) || (state != IDLE));
    assign readdata = (hit_done && read && !write) ? sel_byte : readdata_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 6'd0;
        mem_writedata = 32'd0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    next_state = (valid[index] && dirty[index]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {tag_array[index], index};
                mem_writedata = line_data;
                if (!mem_busywait) begin
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = {addr_tag, index};
                if (!mem_busywait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A completed fill always leaves the line clean; CPU writes only land on a hit in IDLE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            data_array <= '0;
            tag_array  <= '0;
            valid      <= '0;
            dirty      <= '0;
            readdata_q <= '0;
        end else begin
            if (fill_done) begin
                data_array[index] <= mem_readdata;
                tag_array[index]  <= addr_tag;
                valid[index]      <= 1'b1;
                dirty[index]      <= 1'b0;
            end else if (hit_done && write) begin
                data_array[index][bit_base +: 8] <= writedata;
                dirty[index]                     <= 1'b1;
            end
            if (hit_done && read && !write) begin
                readdata_q <= sel_byte;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic miss_start;
    assign miss_start = (state == IDLE) && req && !hit;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (hit_done && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_start && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: a 5-cycle block memory model plus table-driven CPU accesses.
module tb_data_cache;

    logic        CLK;
    logic        RESET;
    logic        busywait;
    logic        read;
    logic        write;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic [7:0]  address;
    logic        mem_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic [5:0]  mem_address;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .busywait      (busywait),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .address       (address),
        .mem_busywait  (mem_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_address   (mem_address)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: busy for 4 cycles of a held request, completes on the 5th edge.
    logic [31:0] mem [64];
    int          mem_cnt;

    initial begin
        mem_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 4; k++) begin
                mem[i][8*k +: 8] = 8'(4*i + k) ^ 8'hA5;
            end
        end
    end

    assign mem_busywait = (mem_read || mem_write) && (mem_cnt != 4);
    assign mem_readdata = mem[mem_address];

    always @(posedge CLK) begin
        if (mem_read || mem_write) begin
            if (mem_cnt == 4) begin
                mem_cnt <= 0;
                if (mem_write) begin
                    mem[mem_address] <= mem_writedata;
                end
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    int num_checks = 0;
    int num_fail   = 0;

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    logic        snap_rd    [16];
    logic        snap_wr    [16];
    logic [5:0]  snap_addr  [16];
    logic [31:0] snap_wdata [16];

    // One CPU access held until busywait clears; memory-side outputs are recorded each stalled cycle.
    task automatic apply_stimulus(input bit rd, input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                                  output int stalls, output logic [7:0] rdata);
        @(negedge CLK);
        read      = rd;
        write     = wr;
        address   = addr;
        writedata = wd;
        #1;
        stalls = 0;
        while (busywait && stalls < 40) begin
            @(negedge CLK);
            stalls++;
            if (stalls < 16) begin
                snap_rd[stalls]    = mem_read;
                snap_wr[stalls]    = mem_write;
                snap_addr[stalls]  = mem_address;
                snap_wdata[stalls] = mem_writedata;
            end
        end
        rdata = readdata;
        @(negedge CLK);
        read  = 1'b0;
        write = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_data;
        int          exp_stalls;
        logic [5:0]  exp_addr1;
        bit          exp_wb;
        logic [31:0] exp_wbdata;
        logic [5:0]  exp_addr_alloc;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int         stalls;
        logic [7:0] rdata;

        RESET     = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = 8'h00;
        writedata = 8'h00;

        vecs[0]  = '{1, 0, 8'h00, 8'h00, 8'hA5,  6, 6'd0, 0, 32'h0,        6'd0};
        vecs[1]  = '{0, 1, 8'h05, 8'hAB, 8'h00,  6, 6'd1, 0, 32'h0,        6'd0};
        vecs[2]  = '{1, 0, 8'h05, 8'h00, 8'hAB,  0, 6'd0, 0, 32'h0,        6'd0};
        vecs[3]  = '{1, 0, 8'h04, 8'h00, 8'hA1,  0, 6'd0, 0, 32'h0,        6'd0};
        vecs[4]  = '{1, 0, 8'h25, 8'h00, 8'h80, 11, 6'd1, 1, 32'hA2A3ABA1, 6'd9};
        vecs[5]  = '{1, 0, 8'h05, 8'h00, 8'hAB,  6, 6'd1, 0, 32'h0,        6'd0};
        vecs[6]  = '{1, 1, 8'h06, 8'h3C, 8'h00,  0, 6'd0, 0, 32'h0,        6'd0};
        vecs[7]  = '{1, 0, 8'h06, 8'h00, 8'h3C,  0, 6'd0, 0, 32'h0,        6'd0};
        vecs[8]  = '{1, 0, 8'h07, 8'h00, 8'hA2,  0, 6'd0, 0, 32'h0,        6'd0};
        vecs[9]  = '{0, 1, 8'h1F, 8'h55, 8'h00,  6, 6'd7, 0, 32'h0,        6'd0};
        vecs[10] = '{1, 0, 8'h1F, 8'h00, 8'h55,  0, 6'd0, 0, 32'h0,        6'd0};
        vecs[11] = '{1, 0, 8'hFF, 8'h00, 8'h5A, 11, 6'd7, 1, 32'h55BBB8B9, 6'h3F};
        vecs[12] = '{1, 0, 8'h1F, 8'h00, 8'h55,  6, 6'd7, 0, 32'h0,        6'd0};
        vecs[13] = '{1, 0, 8'h1C, 8'h00, 8'hB9,  0, 6'd0, 0, 32'h0,        6'd0};

        repeat (2) @(negedge CLK);
        check_value("reset busywait",      32'(busywait),      32'h0);
        check_value("reset mem_read",      32'(mem_read),      32'h0);
        check_value("reset mem_write",     32'(mem_write),     32'h0);
        check_value("reset readdata",      32'(readdata),      32'h0);
        check_value("reset mem_address",   32'(mem_address),   32'h0);
        check_value("reset mem_writedata", mem_writedata,      32'h0);
        RESET = 1'b1;

        for (int v = 0; v < 14; v++) begin
            apply_stimulus(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, stalls, rdata);
            check_value($sformatf("vec%0d stalls", v), 32'(stalls), 32'(vecs[v].exp_stalls));
            if (vecs[v].rd && !vecs[v].wr) begin
                check_value($sformatf("vec%0d readdata", v), 32'(rdata), 32'(vecs[v].exp_data));
            end
            if (vecs[v].exp_stalls > 0) begin
                check_value($sformatf("vec%0d first mem_read", v),  32'(snap_rd[1]),   32'(!vecs[v].exp_wb));
                check_value($sformatf("vec%0d first mem_write", v), 32'(snap_wr[1]),   32'(vecs[v].exp_wb));
                check_value($sformatf("vec%0d first mem_addr", v),  32'(snap_addr[1]), 32'(vecs[v].exp_addr1));
            end
            if (vecs[v].exp_wb) begin
                check_value($sformatf("vec%0d victim data", v),    snap_wdata[1],  vecs[v].exp_wbdata);
                check_value($sformatf("vec%0d alloc mem_read", v), 32'(snap_rd[6]),  32'h1);
                check_value($sformatf("vec%0d alloc mem_write", v), 32'(snap_wr[6]), 32'h0);
                check_value($sformatf("vec%0d alloc mem_addr", v), 32'(snap_addr[6]), 32'(vecs[v].exp_addr_alloc));
            end
            if (vecs[v].rd && !vecs[v].wr) begin
                @(negedge CLK);
                check_value($sformatf("vec%0d readdata held", v), 32'(readdata), 32'(vecs[v].exp_data));
            end
        end

        // Reset in the middle of an allocate: request must vanish and the cache must forget its lines.
        @(negedge CLK);
        read    = 1'b1;
        address = 8'h40;
        repeat (3) @(negedge CLK);
        check_value("pre-reset mem_read", 32'(mem_read), 32'h1);
        check_value("pre-reset busywait", 32'(busywait), 32'h1);
        RESET = 1'b0;
        #1;
        check_value("mid-reset mem_read",    32'(mem_read),    32'h0);
        check_value("mid-reset busywait",    32'(busywait),    32'h0);
        check_value("mid-reset mem_address", 32'(mem_address), 32'h0);
        @(negedge CLK);
        read  = 1'b0;
        RESET = 1'b1;

        apply_stimulus(1, 0, 8'h40, 8'h00, stalls, rdata);
        check_value("post-reset 0x40 stalls",   32'(stalls),       32'd6);
        check_value("post-reset 0x40 mem_addr", 32'(snap_addr[1]), 32'h10);
        check_value("post-reset 0x40 data",     32'(rdata),        32'hE5);
        apply_stimulus(1, 0, 8'h05, 8'h00, stalls, rdata);
        check_value("post-reset 0x05 stalls", 32'(stalls), 32'd6);
        check_value("post-reset 0x05 data",   32'(rdata),  32'hAB);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
